// File: rtl/audio_sample_feeder_if.sv
// USI slave bus bundle for the audio sample feeder.
// iSUsiWCke is a one-cycle write strobe. When the block is selected and no
// write is strobed, the read is answered one cycle later with oSUsiREd=1 and oSUsiRd.
interface audio_sample_feeder_if #(
    parameter int pBusAdrsBit = 15
);
    logic [31:0]          iSUsiWd;
    logic [pBusAdrsBit:0] iSUsiAdrs;
    logic                 iSUsiWCke;
    logic [31:0]          oSUsiRd;
    logic                 oSUsiREd;

    modport master (
        output iSUsiWd, iSUsiAdrs, iSUsiWCke,
        input  oSUsiRd, oSUsiREd
    );

    modport slave (
        input  iSUsiWd, iSUsiAdrs, iSUsiWCke,
        output oSUsiRd, oSUsiREd
    );
endinterface

// File: rtl/audio_sample_feeder.sv
// PCM sample FIFO with a programmable sample-rate timer feeding the PWM duty value.
// Also provides the register file, sticky error flags and the low-water interrupt.
module audio_sample_feeder #(
    parameter int pBlockAdrsMap = 8,
    parameter int pAdrsMap      = 2,
    parameter int pBusAdrsBit   = 15,
    parameter int pFifoDepth    = 16,
    parameter int pSampleWidth  = 8
) (
    input  logic                    iSysClk,
    input  logic                    iSysRst,
    audio_sample_feeder_if.slave    usi,
    output logic [pSampleWidth-1:0] oDuty,
    output logic                    oDutyVd,
    output logic                    oIrq
);
    localparam int PW = $clog2(pFifoDepth);
    localparam int LW = PW + 1;
    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_RATE   = 8'h04;
    localparam logic [7:0] OFS_DATA   = 8'h08;
    localparam logic [7:0] OFS_STATUS = 8'h0C;
    localparam logic [7:0] OFS_THRESH = 8'h10;

    logic                    en_q, en_d;
    logic [15:0]             rate_q, rate_d;
    logic [15:0]             rate_act_q, rate_act_d;
    logic [15:0]             timer_q, timer_d;
    logic [7:0]              thresh_q, thresh_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic [pSampleWidth-1:0] duty_q, duty_d;
    logic                    duty_vd_q, duty_vd_d;
    logic                    irq_q, irq_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_vd_q, rd_vd_d;
    logic [pSampleWidth-1:0] mem_q [pFifoDepth];

    logic       sel, wr, full, empty;
    logic       push_req, pop_req, clear, do_push, do_pop;
    logic [7:0] ofs;
    logic [31:0] level_ext;
    logic       unused_wd_bits;

    assign sel       = (usi.iSUsiAdrs[pBusAdrsBit -: pBlockAdrsMap] == pBlockAdrsMap'(pAdrsMap));
    assign wr        = sel && usi.iSUsiWCke;
    assign ofs       = usi.iSUsiAdrs[7:0];
    assign full      = (level_q == LW'(pFifoDepth));
    assign empty     = (level_q == '0);
    assign level_ext = 32'(level_q);
    assign unused_wd_bits = ^usi.iSUsiWd[31:16];

    always_comb begin
        en_d       = en_q;
        rate_d     = rate_q;
        rate_act_d = rate_act_q;
        timer_d    = timer_q;
        thresh_d   = thresh_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        duty_d     = duty_q;
        duty_vd_d  = 1'b0;
        rd_data_d  = '0;
        rd_vd_d    = 1'b0;

        push_req = wr && (ofs == OFS_DATA);
        clear    = wr && (ofs == OFS_CTRL) && usi.iSUsiWd[1];
        pop_req  = en_q && (timer_q == rate_act_q);
        do_pop   = pop_req && !empty && !clear;
        // A full FIFO still accepts a push when the same cycle pops a slot free.
        do_push  = push_req && !clear && (!full || do_pop);

        if (wr && ofs == OFS_CTRL)   en_d     = usi.iSUsiWd[0];
        if (wr && ofs == OFS_RATE)   rate_d   = usi.iSUsiWd[15:0];
        if (wr && ofs == OFS_THRESH) thresh_d = usi.iSUsiWd[7:0];

        // New RATE values only reach the counter at a period boundary.
        if (!en_q) begin
            timer_d    = '0;
            rate_act_d = rate_q;
        end else if (pop_req) begin
            timer_d    = '0;
            rate_act_d = rate_q;
        end else begin
            timer_d = timer_q + 16'd1;
        end

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop) level_d = level_q + LW'(1);
            if (do_pop && !do_push) level_d = level_q - LW'(1);
        end

        if (do_pop) begin
            duty_d    = mem_q[rd_ptr_q];
            duty_vd_d = 1'b1;
        end

        // Set beats a simultaneous write-one-to-clear.
        ovf_d = (push_req && !clear && full && !do_pop) ||
                (ovf_q && !(wr && ofs == OFS_STATUS && usi.iSUsiWd[10]));
        udf_d = (pop_req && empty && !clear) ||
                (udf_q && !(wr && ofs == OFS_STATUS && usi.iSUsiWd[11]));

        irq_d = en_q && (level_ext < 32'(thresh_q));

        rd_vd_d = sel && !usi.iSUsiWCke;
        if (rd_vd_d) begin
            case (ofs)
                OFS_CTRL:   rd_data_d = {31'd0, en_q};
                OFS_RATE:   rd_data_d = {16'd0, rate_q};
                OFS_STATUS: rd_data_d = {20'd0, udf_q, ovf_q, full, empty, level_ext[7:0]};
                OFS_THRESH: rd_data_d = {24'd0, thresh_q};
                default:    rd_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            en_q       <= 1'b0;
            rate_q     <= '0;
            rate_act_q <= '0;
            timer_q    <= '0;
            thresh_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            duty_q     <= '0;
            duty_vd_q  <= 1'b0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_vd_q    <= 1'b0;
        end else begin
            en_q       <= en_d;
            rate_q     <= rate_d;
            rate_act_q <= rate_act_d;
            timer_q    <= timer_d;
            thresh_q   <= thresh_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            duty_q     <= duty_d;
            duty_vd_q  <= duty_vd_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_vd_q    <= rd_vd_d;
        end
    end

    // Sample storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge iSysClk) begin
        if (do_push) mem_q[wr_ptr_q] <= usi.iSUsiWd[pSampleWidth-1:0];
    end

    assign oDuty        = duty_q;
    assign oDutyVd      = duty_vd_q;
    assign oIrq         = irq_q;
    assign usi.oSUsiRd  = rd_data_q;
    assign usi.oSUsiREd = rd_vd_q;
endmodule

// File: tb/tb_audio_sample_feeder.sv
// Directed bench for audio_sample_feeder: register access, sample timing,
// FIFO boundaries, low-water interrupt and asynchronous reset.
module tb_audio_sample_feeder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] duty;
    logic duty_vd;
    logic irq;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    audio_sample_feeder_if #(.pBusAdrsBit(15)) usi ();

    audio_sample_feeder dut (
        .iSysClk (clk),
        .iSysRst (rst),
        .usi     (usi.slave),
        .oDuty   (duty),
        .oDutyVd (duty_vd),
        .oIrq    (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks: all start and end on a falling edge
    task automatic bus_write(input logic [15:0] adrs, input logic [31:0] data);
        usi.iSUsiAdrs = adrs;
        usi.iSUsiWd   = data;
        usi.iSUsiWCke = 1'b1;
        @(negedge clk);
        usi.iSUsiWCke = 1'b0;
        usi.iSUsiAdrs = '0;
        usi.iSUsiWd   = '0;
    endtask

    task automatic bus_read(input logic [15:0] adrs, output logic [31:0] data, output logic vd);
        usi.iSUsiAdrs = adrs;
        usi.iSUsiWCke = 1'b0;
        @(negedge clk);
        data = usi.oSUsiRd;
        vd   = usi.oSUsiREd;
        usi.iSUsiAdrs = '0;
    endtask

    task automatic push_sample(input logic [W-1:0] v);
        bus_write(16'h0208, {24'd0, v});
        exp_q.push_back(v);
    endtask

    task automatic read_check(input string tag, input logic [15:0] adrs, input logic [31:0] exp);
        logic [31:0] d;
        logic v;
        bus_read(adrs, d, v);
        check_eq({tag, "_vd"}, {31'd0, v}, 32'd1);
        check_eq(tag, d, exp);
    endtask

    task automatic wait_vd(input int max_cycles, output int n);
        n = 0;
        while (n < max_cycles) begin
            @(negedge clk);
            n++;
            if (duty_vd) break;
        end
    endtask

    // scoreboard: every duty strobe must present the next queued sample
    always @(negedge clk) begin
        if (!rst && duty_vd) begin
            if (exp_q.size() == 0) check_eq("duty_unexpected", {31'd0, duty_vd}, 32'd0);
            else                   check_eq("duty", {24'd0, duty}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic [31:0] d;
        logic v;

        usi.iSUsiWd   = '0;
        usi.iSUsiAdrs = '0;
        usi.iSUsiWCke = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_duty", {24'd0, duty}, 32'd0);
        check_eq("rst_vd", {31'd0, duty_vd}, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_red", {31'd0, usi.oSUsiREd}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        read_check("rst_status", 16'h020C, 32'h100);
        read_check("rst_ctrl", 16'h0200, 32'h0);

        // sample period 100 clocks, three samples then an underrun
        bus_write(16'h0204, 32'd99);
        push_sample(8'h10);
        push_sample(8'h20);
        push_sample(8'h30);
        bus_write(16'h0200, 32'd1);
        wait_vd(150, n); check_eq("gap1", n, 100);
        wait_vd(150, n); check_eq("gap2", n, 100);
        wait_vd(150, n); check_eq("gap3", n, 100);
        repeat (100) @(negedge clk);
        check_eq("udf_vd", {31'd0, duty_vd}, 32'd0);
        check_eq("udf_duty_hold", {24'd0, duty}, 32'h30);
        read_check("udf_status", 16'h020C, 32'h900);
        bus_write(16'h0200, 32'd0);
        bus_write(16'h020C, 32'h800);
        read_check("udf_cleared", 16'h020C, 32'h100);

        // overflow while disabled
        for (int i = 0; i < 16; i++) push_sample(8'h40 + 8'(i));
        bus_write(16'h0208, 32'hEE);
        read_check("ovf_status", 16'h020C, 32'h610);
        bus_write(16'h020C, 32'h400);
        read_check("ovf_cleared", 16'h020C, 32'h210);

        // RATE=0, full FIFO, push every cycle
        bus_write(16'h0204, 32'd0);
        bus_write(16'h0200, 32'd1);
        for (int i = 0; i < 20; i++) begin
            usi.iSUsiAdrs = 16'h0208;
            usi.iSUsiWd   = 32'h80 + 32'(i);
            usi.iSUsiWCke = 1'b1;
            exp_q.push_back(8'h80 + 8'(i));
            @(negedge clk);
            check_eq("b2b_vd", {31'd0, duty_vd}, 32'd1);
        end
        bus_write(16'h0200, 32'd0);
        read_check("b2b_status", 16'h020C, 32'h00F);
        bus_write(16'h0200, 32'd2);
        exp_q.delete();
        read_check("clr_status", 16'h020C, 32'h100);

        // low-water interrupt and clear while running
        bus_write(16'h0210, 32'd4);
        for (int i = 1; i <= 6; i++) push_sample(8'h60 + 8'(i));
        bus_write(16'h0204, 32'd9);
        check_eq("irq_disabled", {31'd0, irq}, 32'd0);
        bus_write(16'h0200, 32'd1);
        wait_vd(20, n); check_eq("irq_gap1", n, 10);
        check_eq("irq_lvl5", {31'd0, irq}, 32'd0);
        wait_vd(20, n); check_eq("irq_gap2", n, 10);
        wait_vd(20, n); check_eq("irq_gap3", n, 10);
        check_eq("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check_eq("irq_lvl3", {31'd0, irq}, 32'd1);
        bus_write(16'h0200, 32'd3);
        exp_q.delete();
        check_eq("irq_after_clr", {31'd0, irq}, 32'd1);
        read_check("irq_clr_status", 16'h020C, 32'h100);
        check_eq("irq_hold", {31'd0, irq}, 32'd1);
        bus_write(16'h0200, 32'd0);
        bus_write(16'h020C, 32'h800);

        // register map and address decode
        read_check("rate_rb", 16'h0204, 32'd9);
        read_check("thresh_rb", 16'h0210, 32'd4);
        read_check("data_rd0", 16'h0208, 32'd0);
        read_check("unmapped", 16'h0214, 32'd0);
        bus_read(16'h030C, d, v);
        check_eq("other_blk_vd", {31'd0, v}, 32'd0);
        check_eq("other_blk_rd", d, 32'd0);

        // asynchronous reset mid-stream
        bus_write(16'h0204, 32'd4);
        push_sample(8'h91);
        push_sample(8'h92);
        push_sample(8'h93);
        bus_write(16'h0200, 32'd1);
        wait_vd(20, n); check_eq("pre_rst_gap", n, 5);
        usi.iSUsiAdrs = 16'h020C;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_duty", {24'd0, duty}, 32'd0);
        check_eq("arst_vd", {31'd0, duty_vd}, 32'd0);
        check_eq("arst_irq", {31'd0, irq}, 32'd0);
        check_eq("arst_red", {31'd0, usi.oSUsiREd}, 32'd0);
        check_eq("arst_rd", usi.oSUsiRd, 32'd0);
        exp_q.delete();
        usi.iSUsiAdrs = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_check("post_rst_status", 16'h020C, 32'h100);
        read_check("post_rst_thresh", 16'h0210, 32'd0);
        push_sample(8'h71);
        push_sample(8'h72);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (duty_vd) cnt++;
        end
        check_eq("no_pop_wo_enable", cnt, 0);
        bus_write(16'h0200, 32'd1);
        wait_vd(10, n); check_eq("post_rst_gap1", n, 1);
        wait_vd(10, n); check_eq("post_rst_gap2", n, 1);
        bus_write(16'h0200, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_sample_feeder.md
# audio_sample_feeder

Upstream stage of the PWM audio output path. Software pushes 8-bit PCM samples into a small FIFO over the USI slave bus. A programmable sample-rate timer pops one sample per sample period and presents it as the duty value, with a one-cycle valid strobe, to the PWM block that follows. The block also reports FIFO level, sticky overflow/underrun flags and a low-water interrupt.

## Interface
Parameters:
- pBlockAdrsMap, 8: number of upper address bits used for block select.
- pAdrsMap, 2: block-select value matched against iSUsiAdrs[pBusAdrsBit -: pBlockAdrsMap].
- pBusAdrsBit, 15: MSB index of iSUsiAdrs.
- pFifoDepth, 16: FIFO entries; power of two, minimum 4.
- pSampleWidth, 8: sample and duty width.

Ports:
- iSysClk  in  1  system clock; single clock domain.
- iSysRst  in  1  reset, asynchronous, active-high.
- iSUsiWd  in  32  bus write data.
- iSUsiAdrs  in  pBusAdrsBit+1  bus address; low 8 bits are the register offset.
- iSUsiWCke  in  1  write strobe, one cycle per write.
- oSUsiRd  out  32  read data.
- oSUsiREd  out  1  read data valid.
- oDuty  out  pSampleWidth  current duty value to the PWM stage.
- oDutyVd  out  1  one-cycle strobe when oDuty is loaded with a new sample.
- oIrq  out  1  low-water interrupt, level type.

## Operation
- Registers (offset):
  - 0x00 CTRL: bit0 enable; bit1 fifo_clear, write-only and self-clearing.
  - 0x04 RATE: [15:0] sample period minus 1, in clocks.
  - 0x08 DATA: write pushes iSUsiWd[pSampleWidth-1:0]; reads return 0.
  - 0x0C STATUS: [7:0] level, [8] empty, [9] full, [10] overflow sticky, [11] underrun sticky. Writing 1 to bit 10 or 11 clears that bit.
  - 0x10 THRESH: [7:0] low-water level.
  - Unmapped offsets read 0; writes to them are ignored.
- Write acceptance: block selected and iSUsiWCke=1.
- Rate timer: counts 0..RATE while enabled. At terminal count it wraps to 0 and issues a pop request. It is held at 0 while disabled.
- Pop request with FIFO non-empty: oDuty <= head sample, oDutyVd=1 for one cycle, level decrements.
- Pop request with FIFO empty: oDuty holds its previous value, oDutyVd stays 0, underrun is set.
- DATA write when full: sample dropped, overflow set, level unchanged.
- Push and pop in the same cycle:
  - Non-empty and not full: both succeed, level unchanged.
  - Full: both succeed; no overflow.
  - Empty: the push succeeds, the pop sees empty, underrun is set.
- fifo_clear: pointers and level go to 0 and any same-cycle push is discarded. oDuty, sticky flags and other registers are unaffected.
- Disable: the timer stops and the FIFO contents are retained. oDuty holds its value.
- oIrq = enable && (level < THRESH), registered.
- A sticky-flag set event in the same cycle as its W1C clear leaves the flag set (set wins).

## Timing
- Reset values: oSUsiRd=0, oSUsiREd=0, oDuty=0, oDutyVd=0, oIrq=0. CTRL, RATE and THRESH reset to 0; FIFO is empty; sticky flags are 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first timer pop after release needs a new enable.
- Register writes take effect on the clock edge of the strobe. STATUS level reflects a push one cycle later.
- Read: oSUsiREd=1 and oSUsiRd=register at the selected offset, registered, one cycle after the address is presented, whenever the block is selected and iSUsiWCke=0. Otherwise both outputs are 0.
- Enable rising edge at cycle T (CTRL write): the first pop request occurs at T+RATE+1, then every RATE+1 cycles.
- oDuty and oDutyVd are registered and change on the pop-request cycle edge, so the PWM stage sees them together.
- RATE=0 requests a pop every cycle; the FIFO must sustain back-to-back pops.
- A RATE write while running takes effect after the current period wraps.

## Test plan
- Reset, write RATE=99, push 0x10/0x20/0x30, set enable at T -> oDutyVd pulses at T+100, T+200, T+300 with oDuty 0x10, 0x20, 0x30. A fourth pop sets underrun (STATUS bit11=1) and oDuty stays 0x30.
- Push 17 samples with pFifoDepth=16 and enable=0 -> STATUS level=16, full=1, overflow=1. Write 0x400 to STATUS -> overflow=0.
- RATE=0, FIFO full, enable, push every cycle -> no overflow, level stays at 16, oDutyVd high every cycle.
- THRESH=4, push 6 samples, RATE=9, enable -> oIrq=0 until level drops to 3, then oIrq=1. Write CTRL bit1 (with bit0 still set) -> level=0, empty=1, oIrq stays 1.
- Read STATUS at 0x020C -> oSUsiREd=1 next cycle with correct level. Read at 0x030C -> oSUsiREd=0, oSUsiRd=0.
- Assert iSysRst mid-stream -> all outputs 0 and FIFO empty immediately. After release, no oDutyVd until enable is written again.
